// File: rtl/sseg_serial_rx_if.sv
// Signal bundle between a serial seven-segment display driver and its frame receiver.
// The driver side (master) owns the serial lines; the receiver side (slave) owns the frame outputs.
interface sseg_serial_rx_if #(
  parameter int WIDTH = 64
);
  logic             seg_clk;
  logic             seg_sout;
  logic             SEG_PEN;
  logic             seg_clrn;
  logic [WIDTH-1:0] frame_data;
  logic             frame_valid;
  logic [6:0]       bit_cnt;
  logic             frame_err;
  logic             overrun;

  modport master (
    output seg_clk, seg_sout, SEG_PEN, seg_clrn,
    input  frame_data, frame_valid, bit_cnt, frame_err, overrun
  );

  modport slave (
    input  seg_clk, seg_sout, SEG_PEN, seg_clrn,
    output frame_data, frame_valid, bit_cnt, frame_err, overrun
  );
endinterface

// File: rtl/sseg_serial_rx.sv
// Oversampling receiver for a serial display shift-register stream: synchronizes the
// driver's clock/data/latch/clear lines and rebuilds each WIDTH-bit frame on the latch strobe.
module sseg_serial_rx #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           RSTN,
  sseg_serial_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_e;

  // Synchronizer bundle order: {seg_clrn, SEG_PEN, seg_sout, seg_clk}; clear line idles high.
  localparam logic [3:0]    SYNC_RST = 4'b1000;
  localparam int            SW       = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLE   = SW'(SYNC_STAGES + 1);
  localparam logic [6:0]    WIDTH_C  = 7'(WIDTH);

  logic [3:0]       sync_q [SYNC_STAGES];
  logic [1:0]       hist_q;
  logic [SW-1:0]    settle_q;
  state_e           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             ovr_q, ovr_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             frame_valid_q, frame_err_q;

  logic sclk_s, sout_s, pen_s, clrn_s, settled, clk_rise, pen_rise;

  assign sclk_s  = sync_q[SYNC_STAGES-1][0];
  assign sout_s  = sync_q[SYNC_STAGES-1][1];
  assign pen_s   = sync_q[SYNC_STAGES-1][2];
  assign clrn_s  = sync_q[SYNC_STAGES-1][3];
  assign settled = (settle_q == SETTLE);

  // Edges are masked until the chain has refilled after reset, so a line already high
  // at release is not mistaken for a rise.
  assign clk_rise = settled & sclk_s & ~hist_q[0];
  assign pen_rise = settled & pen_s  & ~hist_q[1];

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      hist_q   <= 2'b00;
      settle_q <= '0;
    end else begin
      sync_q[0] <= {bus.seg_clrn, bus.SEG_PEN, bus.seg_sout, bus.seg_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q   <= {pen_s, sclk_s};
      settle_q <= settled ? settle_q : settle_q + SW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    ovr_d   = ovr_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    if (!clrn_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
      frame_d = '0;
      ovr_d   = 1'b0;
    end else begin
      if (clk_rise) begin
        shreg_d = {shreg_q[WIDTH-2:0], sout_s};
        case (state_q)
          IDLE: begin
            cnt_d   = 7'd1;
            state_d = SHIFT;
          end
          SHIFT: begin
            cnt_d = cnt_q + 7'd1;
            if (cnt_q + 7'd1 == WIDTH_C) state_d = FULL;
          end
          FULL:    ovr_d = 1'b1;
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
      // Commit looks at the post-shift state so a simultaneous last bit still counts.
      if (pen_rise) begin
        if (state_d == FULL) begin
          frame_d = shreg_d;
          ok_d    = 1'b1;
          ovr_d   = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      frame_q       <= '0;
      ovr_q         <= 1'b0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      frame_q       <= frame_d;
      ovr_q         <= ovr_d;
      ok_q          <= ok_d;
      err_q         <= err_d;
      frame_valid_q <= ok_q;
      frame_err_q   <= err_q;
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.bit_cnt     = cnt_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_sseg_serial_rx.sv
// Directed-plus-random bench for sseg_serial_rx; expectations come from a bit-queue model
// of the frame protocol (bits since last commit/clear, last committed frame).
module tb_sseg_serial_rx;

  localparam int W  = 64;
  localparam int S  = 2;
  localparam int PH = S + 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sseg_serial_rx_if #(.WIDTH(W)) sif ();

  sseg_serial_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .RSTN(rstn),
    .bus (sif)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  bit           q[$];
  logic [W-1:0] frame_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_frame();
    logic [W-1:0] r = '0;
    int lo = (q.size() > W) ? q.size() - W : 0;
    for (int i = lo; i < q.size(); i++) r = {r[W-2:0], q[i]};
    return r;
  endfunction

  function automatic int model_cnt();
    return (q.size() > W) ? W : q.size();
  endfunction

  task automatic check_status(string tag);
    chk({tag, "_cnt"}, 64'(sif.bit_cnt), 64'(model_cnt()));
    chk({tag, "_ovr"}, 64'(sif.overrun), 64'(q.size() > W));
  endtask

  task automatic shift_bit(bit b);
    sif.seg_sout = b;
    sif.seg_clk  = 1'b0;
    repeat (PH) tick();
    sif.seg_clk = 1'b1;
    repeat (PH) tick();
    q.push_back(b);
  endtask

  task automatic shift_word(logic [63:0] v, int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic shift_rand(int n);
    repeat (n) shift_bit(1'($urandom));
  endtask

  // Latch strobe, optionally with one more seg_clk rise on the very same clk edge.
  task automatic commit(string tag, bit with_shift, bit b);
    int nv = 0, ne = 0, nb = 0, tv = 0, te = 0;
    bit full;
    logic [W-1:0] exp_f;
    if (with_shift) begin
      sif.seg_sout = b;
      sif.seg_clk  = 1'b0;
      repeat (PH) tick();
      q.push_back(b);
    end
    full  = (q.size() >= W);
    exp_f = full ? model_frame() : frame_m;
    if (with_shift) sif.seg_clk = 1'b1;
    sif.SEG_PEN = 1'b1;
    for (int t = 1; t <= S + 6; t++) begin
      tick();
      if (t == 3) sif.SEG_PEN = 1'b0;
      if (sif.frame_valid) begin nv++; tv = t; end
      if (sif.frame_err)   begin ne++; te = t; end
      if (sif.frame_valid && sif.frame_err) nb++;
    end
    chk({tag, "_valid_pulses"}, 64'(nv), 64'(full ? 1 : 0));
    chk({tag, "_err_pulses"}, 64'(ne), 64'(full ? 0 : 1));
    chk({tag, "_both"}, 64'(nb), 64'd0);
    chk({tag, "_latency"}, 64'(full ? tv : te), 64'(S + 2));
    chk({tag, "_frame"}, 64'(sif.frame_data), 64'(exp_f));
    chk({tag, "_cnt_after"}, 64'(sif.bit_cnt), 64'd0);
    chk({tag, "_ovr_after"}, 64'(sif.overrun), 64'd0);
    frame_m = exp_f;
    q.delete();
    n_txn++;
    $display("txn %0d %s: valid=%0d err=%0d frame_data=%h", n_txn, tag, nv, ne, sif.frame_data);
  endtask

  task automatic clear_pulse(string tag);
    sif.seg_clrn = 1'b0;
    repeat (4) tick();
    sif.seg_clrn = 1'b1;
    repeat (S + 2) tick();
    q.delete();
    frame_m = '0;
    check_status(tag);
    chk({tag, "_frame"}, 64'(sif.frame_data), 64'd0);
    $display("clear %s: bit_cnt=%0d frame_data=%h", tag, sif.bit_cnt, sif.frame_data);
  endtask

  initial begin
    int  lens[8] = '{0, 10, W - 1, W, W, W + 1, W + 3, W + 7};
    bit  b;
    sif.seg_clk  = 1'b0;
    sif.seg_sout = 1'b0;
    sif.SEG_PEN  = 1'b0;
    sif.seg_clrn = 1'b1;
    rstn         = 1'b0;
    frame_m      = '0;
    repeat (3) tick();
    chk("rst_frame", 64'(sif.frame_data), 64'd0);
    chk("rst_valid", 64'(sif.frame_valid), 64'd0);
    chk("rst_err", 64'(sif.frame_err), 64'd0);
    chk("rst_cnt", 64'(sif.bit_cnt), 64'd0);
    chk("rst_ovr", 64'(sif.overrun), 64'd0);
    rstn = 1'b1;
    repeat (PH + 1) tick();

    shift_word(64'h0123_4567_89AB_CDEF, 64);
    check_status("full64");
    commit("full64", 1'b0, 1'b0);
    chk("full64_const", 64'(sif.frame_data), 64'h0123_4567_89AB_CDEF);

    shift_rand(40);
    check_status("part40");
    commit("part40", 1'b0, 1'b0);

    // 0,1,0,1... so the surviving 64 bits end on a 1.
    for (int i = 0; i < 66; i++) shift_bit(1'(i % 2));
    check_status("ovr66");
    commit("ovr66", 1'b0, 1'b0);
    chk("ovr66_const", 64'(sif.frame_data), 64'h5555_5555_5555_5555);

    shift_rand(30);
    check_status("pre_clear");
    clear_pulse("clr30");
    shift_rand(64);
    commit("after_clr", 1'b0, 1'b0);

    shift_rand(63);
    b = 1'($urandom);
    commit("same_edge", 1'b1, b);
    chk("same_edge_bit0", 64'(sif.frame_data[0]), 64'(b));

    shift_rand(20);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    q.delete();
    frame_m = '0;
    repeat (2 * PH + 2) tick();
    check_status("post_rst");
    chk("post_rst_frame", 64'(sif.frame_data), 64'd0);
    shift_bit(1'b1);
    check_status("first_after_rst");
    shift_rand(63);
    commit("after_rst", 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      shift_rand(lens[$urandom_range(7, 0)]);
      check_status("rand_pre");
      commit("rand", 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
